// File: rtl/lfsr_prbs_check_pkg.sv
// Shared types and helpers for the PRBS read-back checker and its expected-data generator.
package lfsr_prbs_check_pkg;

  localparam int unsigned WORD_SIZE = 48;
  localparam int unsigned PC_W      = $clog2(WORD_SIZE + 1);

  typedef enum logic [2:0] {StIdle, StSeed, StCheck, StFlush, StDone} chk_state_e;

  function automatic logic [PC_W-1:0] popcount(input logic [WORD_SIZE-1:0] w);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      n = n + PC_W'(w[i]);
    end
    return n;
  endfunction

  // XNOR LFSR, taps 48/47/21/20 (all-zero seed is legal); one word = WORD_SIZE fresh bits.
  function automatic logic [WORD_SIZE-1:0] lfsr_next_word(input logic [WORD_SIZE-1:0] s);
    logic [WORD_SIZE-1:0] r;
    r = s;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      r = {r[WORD_SIZE-2:0], ~(r[47] ^ r[46] ^ r[20] ^ r[19])};
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_prbs_check_if.sv
// Read-back word stream into the checker: valid/ready handshake plus data word.
interface lfsr_prbs_check_if;
  import lfsr_prbs_check_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/lfsr_prbs_check_gen.sv
// Expected-data source: same word sequence as the paired PRBS generator, advanced per accept.
module lfsr_prbs_check_gen
  import lfsr_prbs_check_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] LFSR_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [WORD_SIZE-1:0] data_out
);

  logic [WORD_SIZE-1:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_INIT;
    end else if (clr) begin
      state_q <= LFSR_INIT;
    end else if (en) begin
      state_q <= lfsr_next_word(state_q);
    end
  end

  assign data_out = state_q;

endmodule

// File: rtl/lfsr_prbs_check.sv
// PRBS read-back checker: compares accepted words against the regenerated stream and keeps
// saturating bit/word error counts plus a snapshot of the first failing word.
module lfsr_prbs_check
  import lfsr_prbs_check_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] LFSR_INIT = '0,
  parameter int unsigned          CNT_W     = 32,
  parameter int unsigned          IDX_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_words,
  lfsr_prbs_check_if.slave     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_bits,
  output logic [IDX_W-1:0]     err_words,
  output logic [IDX_W-1:0]     first_err_idx,
  output logic [WORD_SIZE-1:0] first_err_mask,
  output logic                 first_err_vld
);

  localparam int unsigned SumW = CNT_W + 1;

  chk_state_e           state_q, state_d;
  logic [IDX_W-1:0]     num_words_q, idx_q, s0_idx_q;
  logic                 s0_vld_q;
  logic [WORD_SIZE-1:0] s0_mask_q, exp_data;
  logic [CNT_W-1:0]     err_bits_q, err_bits_d;
  logic [IDX_W-1:0]     err_words_q, err_words_d, first_idx_q;
  logic [WORD_SIZE-1:0] first_mask_q;
  logic                 first_vld_q, done_q, pass_q;
  logic                 ready, accept, last, clr_run;
  logic [SumW-1:0]      bits_sum;

  assign ready        = (state_q == StCheck);
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid && ready;
  assign last         = accept && (num_words_q != '0) && (idx_q == num_words_q - 1'b1);
  // A start anywhere discards the current run, including a word in flight in stage 0.
  assign clr_run      = start || (state_q == StSeed);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StSeed:  state_d = StCheck;
      StCheck: if (last) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (start) state_d = StSeed;
  end

  lfsr_prbs_check_gen #(
    .LFSR_INIT (LFSR_INIT)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_run),
    .en       (accept),
    .data_out (exp_data)
  );

  always_comb begin
    bits_sum    = {1'b0, err_bits_q} + SumW'(popcount(s0_mask_q));
    err_bits_d  = err_bits_q;
    err_words_d = err_words_q;
    if (s0_vld_q) begin
      err_bits_d = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
      if ((s0_mask_q != '0) && (err_words_q != '1)) err_words_d = err_words_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      num_words_q  <= '0;
      idx_q        <= '0;
      s0_vld_q     <= 1'b0;
      s0_mask_q    <= '0;
      s0_idx_q     <= '0;
      err_bits_q   <= '0;
      err_words_q  <= '0;
      first_vld_q  <= 1'b0;
      first_idx_q  <= '0;
      first_mask_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) num_words_q <= num_words;
      if (clr_run) begin
        idx_q        <= '0;
        s0_vld_q     <= 1'b0;
        err_bits_q   <= '0;
        err_words_q  <= '0;
        first_vld_q  <= 1'b0;
        first_idx_q  <= '0;
        first_mask_q <= '0;
        done_q       <= 1'b0;
        pass_q       <= 1'b0;
      end else begin
        s0_vld_q <= accept;
        if (accept) begin
          s0_mask_q <= bus.in_data ^ exp_data;
          s0_idx_q  <= idx_q;
          idx_q     <= idx_q + 1'b1;
        end
        err_bits_q  <= err_bits_d;
        err_words_q <= err_words_d;
        if (s0_vld_q && (s0_mask_q != '0) && !first_vld_q) begin
          first_vld_q  <= 1'b1;
          first_idx_q  <= s0_idx_q;
          first_mask_q <= s0_mask_q;
        end
        // Last word leaves stage 1 during FLUSH, so pass sees its final count.
        if (state_q == StFlush) begin
          done_q <= 1'b1;
          pass_q <= (err_words_d == '0);
        end
      end
    end
  end

  assign busy           = (state_q == StSeed) || (state_q == StCheck) || (state_q == StFlush);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_bits       = err_bits_q;
  assign err_words      = err_words_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_mask = first_mask_q;
  assign first_err_vld  = first_vld_q;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Bench for lfsr_prbs_check: bit-stream PRBS model plus run-level scoreboard, checked per cycle.
module tb_lfsr_prbs_check;
  import lfsr_prbs_check_pkg::*;

  localparam int NW_MAX  = 65536;
  localparam int PhIdle  = 0;
  localparam int PhSeed  = 1;
  localparam int PhCheck = 2;
  localparam int PhFlush = 3;
  localparam int PhDone  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic        busy, done, pass, first_err_vld;
  logic [31:0] err_bits;
  logic [15:0] err_words, first_err_idx;
  logic [47:0] first_err_mask;

  lfsr_prbs_check_if bus ();

  lfsr_prbs_check dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_words      (num_words),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_bits       (err_bits),
    .err_words      (err_words),
    .first_err_idx  (first_err_idx),
    .first_err_mask (first_err_mask),
    .first_err_vld  (first_err_vld)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [47:0] exp_word [NW_MAX];

  // Run-level model of what the checker must report.
  int              m_ph = PhIdle;
  logic [15:0]     m_idx = '0, m_nw = '0, m_pidx = '0, m_fi = '0;
  logic            m_pend = 1'b0, m_fv = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  logic [47:0]     m_pmask = '0, m_fm = '0;
  longint unsigned m_eb = 0;
  int unsigned     m_ew = 0;

  // Words with index in [c_lo, c_hi] are sent corrupted by c_mask.
  int          c_lo = 1, c_hi = 0;
  logic [47:0] c_mask = '0;

  // Stream form of the PRBS: bit k = XNOR of bits k-48, k-47, k-21, k-20; words are 48-bit slices.
  function automatic logic [47:0] next_word(input logic [47:0] prev);
    logic        b [96];
    logic [47:0] w;
    for (int i = 0; i < 48; i++) b[i] = prev[47-i];
    for (int i = 48; i < 96; i++) b[i] = ~(b[i-48] ^ b[i-47] ^ b[i-21] ^ b[i-20]);
    for (int i = 0; i < 48; i++) w[47-i] = b[48+i];
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PhIdle; m_idx = '0; m_pend = 1'b0; m_pmask = '0; m_pidx = '0;
    m_eb = 0; m_ew = 0; m_fv = 1'b0; m_fi = '0; m_fm = '0; m_done = 1'b0; m_pass = 1'b0;
  endtask

  task automatic cmp_cycle();
    logic [116:0] act_v, exp_v;
    act_v = {bus.in_ready, busy, done, pass, first_err_vld, err_bits, err_words,
             first_err_idx, first_err_mask};
    if (rst) exp_v = '0;
    else exp_v = {m_ph == PhCheck, (m_ph == PhSeed) || (m_ph == PhCheck) || (m_ph == PhFlush),
                  m_done, m_pass, m_fv, m_eb[31:0], m_ew[15:0], m_fi, m_fm};
    check("cycle", 128'(act_v), 128'(exp_v));
  endtask

  // One clock: compare mid-cycle, then advance the model on the edge.
  task automatic tick();
    logic        acc;
    logic [47:0] amask;
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc   = (m_ph == PhCheck) && bus.in_valid;
      amask = bus.in_data ^ exp_word[m_idx];
      if (start) begin
        model_reset();
        m_nw = num_words;
        m_ph = PhSeed;
      end else begin
        if (m_pend) begin
          m_eb = m_eb + longint'($countones(m_pmask));
          if (m_eb > 64'hFFFF_FFFF) m_eb = 64'hFFFF_FFFF;
          if (m_pmask != '0) begin
            if (m_ew < 65535) m_ew++;
            if (!m_fv) begin m_fv = 1'b1; m_fi = m_pidx; m_fm = m_pmask; end
          end
        end
        m_pend = acc; m_pmask = amask; m_pidx = m_idx;
        case (m_ph)
          PhSeed:  m_ph = PhCheck;
          PhCheck: if (acc) begin
            if (m_nw != 0 && m_idx == m_nw - 16'd1) m_ph = PhFlush;
            m_idx++;
          end
          PhFlush: begin m_ph = PhDone; m_done = 1'b1; m_pass = (m_ew == 0); end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  // Start a run and feed words with prob% valid until done or until stop_at words accepted.
  task automatic run(input logic [15:0] nw, input int prob, input int stop_at, input int max_cyc);
    logic finished;
    num_words = nw; start = 1'b1; bus.in_valid = 1'b0;
    tick();
    start = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      if (m_done || (stop_at >= 0 && m_ph == PhCheck && int'(m_idx) == stop_at)) begin
        finished = 1'b1;
      end else begin
        bus.in_valid = ($urandom_range(99) < prob);
        bus.in_data  = exp_word[m_idx] ^
                       ((int'(m_idx) >= c_lo && int'(m_idx) <= c_hi) ? c_mask : 48'h0);
        tick();
      end
    end
    bus.in_valid = 1'b0;
    check("run_finished", 128'(finished), 128'(1));
  endtask

  task automatic idle_offer(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [47:0] w1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    exp_word[0] = '0;
    for (int n = 1; n < NW_MAX; n++) exp_word[n] = next_word(exp_word[n-1]);
    w1 = exp_word[1];
    check("model_w0", 128'(exp_word[0]), 128'(0));
    check("model_w1_top", 128'(w1[47:26]), 128'(22'h3F_FFFD));

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_ready", 128'(bus.in_ready), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_err_bits", 128'(err_bits), 128'(0));

    // Loopback with valid every cycle.
    run(16'd65535, 100, -1, 70000);
    check("loop_done", 128'(done), 128'(1));
    check("loop_pass", 128'(pass), 128'(1));
    check("loop_err_bits", 128'(err_bits), 128'(0));
    check("loop_busy", 128'(busy), 128'(0));

    // Single bit flip.
    c_lo = 100; c_hi = 100; c_mask = 48'h20;
    run(16'd200, 100, -1, 400);
    check("flip_err_bits", 128'(err_bits), 128'(1));
    check("flip_err_words", 128'(err_words), 128'(1));
    check("flip_first_idx", 128'(first_err_idx), 128'(100));
    check("flip_first_mask", 128'(first_err_mask), 128'(48'h20));

    // Burst of two fully inverted words, then words offered while DONE.
    c_lo = 3; c_hi = 4; c_mask = '1;
    run(16'd10, 100, -1, 100);
    idle_offer(5);
    check("burst_err_bits", 128'(err_bits), 128'(96));
    check("burst_err_words", 128'(err_words), 128'(2));
    check("burst_first_idx", 128'(first_err_idx), 128'(3));
    check("burst_pass", 128'(pass), 128'(0));

    // Backpressure.
    c_lo = 1; c_hi = 0;
    run(16'd1000, 50, -1, 10000);
    check("bp_pass", 128'(pass), 128'(1));
    check("bp_err_words", 128'(err_words), 128'(0));

    // Abort a run with errors, then a clean restart.
    c_lo = 10; c_hi = 12; c_mask = {$urandom, $urandom} | 48'h1;
    run(16'd1000, 80, 500, 5000);
    check("abort_err_words", 128'(err_words), 128'(3));
    check("abort_first_idx", 128'(first_err_idx), 128'(10));
    c_lo = 1; c_hi = 0;
    run(16'd200, 100, -1, 400);
    check("restart_err_bits", 128'(err_bits), 128'(0));
    check("restart_pass", 128'(pass), 128'(1));
    check("restart_first_vld", 128'(first_err_vld), 128'(0));

    // Free-running run never finishes on its own.
    run(16'd0, 70, 300, 2000);
    check("free_done", 128'(done), 128'(0));
    check("free_busy", 128'(busy), 128'(1));

    // Reset in the middle of a run.
    c_lo = 5; c_hi = 5; c_mask = 48'h1;
    run(16'd100, 100, 20, 500);
    check("pre_rst_err_bits", 128'(err_bits), 128'(1));
    rst = 1'b1;
    #1;
    check("rst_ready", 128'(bus.in_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err_bits", 128'(err_bits), 128'(0));
    check("rst_first_vld", 128'(first_err_vld), 128'(0));
    repeat (3) tick();
    rst = 1'b0;
    tick();
    c_lo = 1; c_hi = 0;
    run(16'd50, 100, -1, 200);
    check("post_rst_pass", 128'(pass), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
